// File: rtl/dmem_pkg.sv
// ============================================================================
// Module : dmem_pkg
// Brief  : Shared types, legal byte-enable/offset pairs and the be_legal helper
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] C_BE_B0   = 4'b0001;
    localparam logic [3:0] C_BE_B1   = 4'b0010;
    localparam logic [3:0] C_BE_B2   = 4'b0100;
    localparam logic [3:0] C_BE_B3   = 4'b1000;
    localparam logic [3:0] C_BE_H0   = 4'b0011;
    localparam logic [3:0] C_BE_H1   = 4'b1100;
    localparam logic [3:0] C_BE_W    = 4'b1111;

    localparam logic [1:0] C_OFF_0   = 2'b00;
    localparam logic [1:0] C_OFF_1   = 2'b01;
    localparam logic [1:0] C_OFF_2   = 2'b10;
    localparam logic [1:0] C_OFF_3   = 2'b11;

    // A store is legal only for naturally aligned byte, half-word and word accesses.
    function automatic logic be_legal(input logic [3:0] be, input logic [1:0] off);
        logic w_ok;
        w_ok = 1'b0;
        case ({be, off})
            {C_BE_B0, C_OFF_0}: w_ok = 1'b1;
            {C_BE_B1, C_OFF_1}: w_ok = 1'b1;
            {C_BE_B2, C_OFF_2}: w_ok = 1'b1;
            {C_BE_B3, C_OFF_3}: w_ok = 1'b1;
            {C_BE_H0, C_OFF_0}: w_ok = 1'b1;
            {C_BE_H1, C_OFF_2}: w_ok = 1'b1;
            {C_BE_W,  C_OFF_0}: w_ok = 1'b1;
            default:            w_ok = 1'b0;
        endcase
        return w_ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_be_array.sv
// ============================================================================
// Module : dmem_be_array
// Brief  : Word memory with four byte-lane write enables; read data is the
//          post-write word, registered on the access edge.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_be_array #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    input  logic [AW-1:0] i_addr,
    input  logic [3:0]    i_be,
    input  logic [31:0]   i_wd,
    output logic [31:0]   o_rd
);

    localparam int C_DEPTH = 1 << AW;

    logic [31:0] r_mem [C_DEPTH];
    logic [31:0] w_merged;
    logic [31:0] r_rd;

    // Read-after-write: lanes being written come from i_wd, the rest from storage.
    always_comb begin
        w_merged = r_mem[i_addr];
        for (int i = 0; i < 4; i++) begin
            if (i_be[i]) begin
                w_merged[8*i +: 8] = i_wd[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int i = 0; i < 4; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wd[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd <= 32'h0;
        end else if (i_en) begin
            r_rd <= w_merged;
        end
    end

    assign o_rd = r_rd;

endmodule

`default_nettype wire

// File: rtl/dmem_be_responder.sv
// ============================================================================
// Module : dmem_be_responder
// Brief  : Single-outstanding data-memory responder with byte-lane stores and
//          a programmable wait. Optional store-pattern check: DMEM_BE_CHECK_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_be_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_be,
    input  logic [31:0]       req_wd,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rd,
    output logic              rsp_err
);

    localparam int         C_WA   = ADDR_W - 2;
    localparam logic [3:0] C_WAIT = 4'(WAIT_CYC);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic              r_ready;
    logic              w_accept;
    logic              w_access;

    logic              r_we;
    logic [C_WA-1:0]   r_waddr;
    logic [3:0]        r_be;
    logic [31:0]       r_wd;

    logic              w_cur_we;
    logic [C_WA-1:0]   w_cur_waddr;
    logic [3:0]        w_cur_be;
    logic [31:0]       w_cur_wd;
    logic [3:0]        w_lane_we;

    assign w_accept = req_valid & r_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_state_nxt == ST_IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_access    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (C_WAIT == 4'd0) begin
                        w_state_nxt = ST_RESP;
                        w_access    = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = C_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = ST_RESP;
                    w_access    = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_be    <= 4'd0;
            r_wd    <= 32'h0;
        end else if (w_accept && (r_state == ST_IDLE)) begin
            r_we    <= req_we;
            r_waddr <= req_addr[ADDR_W-1:2];
            r_be    <= req_be;
            r_wd    <= req_wd;
        end
    end

    // With zero wait the access happens on the accept edge, before the latches load.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_cur_we    = req_we;
            w_cur_waddr = req_addr[ADDR_W-1:2];
            w_cur_be    = req_be;
            w_cur_wd    = req_wd;
        end else begin
            w_cur_we    = r_we;
            w_cur_waddr = r_waddr;
            w_cur_be    = r_be;
            w_cur_wd    = r_wd;
        end
    end

`ifdef DMEM_BE_CHECK_EN
    logic       r_off;
    logic [1:0] r_off_q;
    logic [1:0] w_cur_off;
    logic       w_illegal;
    logic       r_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_off_q <= 2'd0;
        end else if (w_accept && (r_state == ST_IDLE)) begin
            r_off_q <= req_addr[1:0];
        end
    end

    assign w_cur_off = (r_state == ST_IDLE) ? req_addr[1:0] : r_off_q;
    assign w_illegal = w_cur_we & ~be_legal(w_cur_be, w_cur_off);
    assign w_lane_we = (w_cur_we && !w_illegal) ? w_cur_be : 4'd0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
            r_off <= 1'b0;
        end else if (w_access) begin
            r_err <= w_illegal;
            r_off <= ^w_cur_off;
        end
    end

    logic w_unused_off;
    assign w_unused_off = r_off;
    assign rsp_err      = r_err;
`else
    logic w_unused_off;
    assign w_unused_off = ^req_addr[1:0];
    assign w_lane_we    = w_cur_we ? w_cur_be : 4'd0;
    assign rsp_err      = 1'b0;
`endif

    dmem_be_array #(
        .AW (C_WA)
    ) u_array (
        .clk    (clk),
        .rst_n  (reset_n),
        .i_en   (w_access),
        .i_addr (w_cur_waddr),
        .i_be   (w_lane_we),
        .i_wd   (w_cur_wd),
        .o_rd   (rsp_rd)
    );

    assign req_ready = r_ready;
    assign rsp_valid = (r_state == ST_RESP);

endmodule

`default_nettype wire

// File: tb/tb_dmem_be_responder.sv
// ============================================================================
// Module : tb_dmem_be_responder
// Brief  : Directed scoreboard bench for dmem_be_responder (WAIT_CYC = 2).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_be_responder;

    localparam int ADDR_W   = 12;
    localparam int WAIT_CYC = 2;

    logic              clk;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        req_be;
    logic [31:0]       req_wd;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rd;
    logic              rsp_err;

    int checks;
    int errors;
    logic [32:0] exp_q[$];

    dmem_be_responder #(
        .ADDR_W   (ADDR_W),
        .WAIT_CYC (WAIT_CYC)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_be    (req_be),
        .req_wd    (req_wd),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rd    (rsp_rd),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [32:0] e;
        if (reset_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rd 0x%08h with empty scoreboard", rsp_rd);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rd", rsp_rd, e[31:0]);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e[32]});
            end
        end
    end

    task automatic run_txn(input logic we, input logic [ADDR_W-1:0] addr, input logic [3:0] be,
                           input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                           input int hold);
        int n;
        logic [31:0] held;
        exp_q.push_back({exp_err, exp_rd});
        @(negedge clk);
        rsp_ready = (hold == 0);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_be    = be;
        req_wd    = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = addr ^ 12'h0F0;
        req_be    = ~be;
        req_wd    = ~wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
        chk("rsp_latency", n, WAIT_CYC + 1);
        if (hold > 0) begin
            held = rsp_rd;
            repeat (hold) begin
                @(negedge clk);
                chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
                chk("stall_rd", rsp_rd, held);
                chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
            end
            @(posedge clk);
            #1;
            rsp_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        chk("post_hs_valid", {31'd0, rsp_valid}, 32'd0);
        chk("post_hs_req_ready", {31'd0, req_ready}, 32'd1);
        rsp_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w_after_bad;
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_be    = 4'd0;
        req_wd    = 32'h0;
        rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rd", rsp_rd, 32'h0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_release_ready", {31'd0, req_ready}, 32'd1);

        run_txn(1'b1, 12'h010, 4'b1111, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 0);
        run_txn(1'b1, 12'h011, 4'b0010, 32'h0000AA00, 32'hDEADAAEF, 1'b0, 0);
        run_txn(1'b0, 12'h010, 4'b1111, 32'h55555555, 32'hDEADAAEF, 1'b0, 0);
        run_txn(1'b1, 12'h012, 4'b1100, 32'h12340000, 32'h1234AAEF, 1'b0, 5);

        // Reset in the middle of a pending store must drop it.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 12'h010;
        req_be    = 4'b1111;
        req_wd    = 32'h0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("wait_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("wait_rst_ready", {31'd0, req_ready}, 32'd0);
        chk("wait_rst_rd", rsp_rd, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("wait_rst_release_ready", {31'd0, req_ready}, 32'd1);

        run_txn(1'b0, 12'h010, 4'b0000, 32'h0, 32'h1234AAEF, 1'b0, 0);

`ifdef DMEM_BE_CHECK_EN
        w_after_bad = 32'h1234AAEF;
        run_txn(1'b1, 12'h011, 4'b0110, 32'h00BBCC00, w_after_bad, 1'b1, 0);
`else
        w_after_bad = 32'h12BBCCEF;
        run_txn(1'b1, 12'h011, 4'b0110, 32'h00BBCC00, w_after_bad, 1'b0, 0);
`endif
        run_txn(1'b0, 12'h010, 4'b1111, 32'h0, w_after_bad, 1'b0, 0);

`ifdef DMEM_BE_CHECK_EN
        run_txn(1'b1, 12'h013, 4'b0000, 32'hFFFFFFFF, w_after_bad, 1'b1, 0);
`else
        run_txn(1'b1, 12'h013, 4'b0000, 32'hFFFFFFFF, w_after_bad, 1'b0, 0);
`endif
        run_txn(1'b0, 12'h011, 4'b0110, 32'h0, w_after_bad, 1'b0, 0);
        run_txn(1'b1, 12'h020, 4'b1111, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 0);
        run_txn(1'b0, 12'h010, 4'b0001, 32'h0, w_after_bad, 1'b0, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_be_responder.md
DMEM_BE_RESPONDER -- requirements
Module: dmem_be_responder

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ADDR_W, 12, byte-address width; memory holds 2**(ADDR_W-2) 32-bit words.
- WAIT_CYC, 2, wait cycles between request accept and response; legal range 0..15.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address from the ALU result.
- req_be  in  4  byte-lane write enables; bit i enables lane i (bits 8i+7:8i).
- req_wd  in  32  lane-positioned store data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rd  out  32  full memory word; the requester performs lane extraction and extension.
- rsp_err  out  1  illegal store pattern flagged.

Function
REQ-003 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-004 req_ready SHALL be 1 only in IDLE; a request is accepted on the rising edge where req_valid and req_ready are both 1.
REQ-005 On accept, the block SHALL latch req_addr[ADDR_W-1:2], req_we, req_be and req_wd; later input changes have no effect.
REQ-006 On accept, the FSM SHALL go to RESP if WAIT_CYC is 0; otherwise it SHALL go to WAIT with the counter loaded with WAIT_CYC.
REQ-007 In WAIT, the counter SHALL decrement each cycle; when the counter is 1, the next state SHALL be RESP.
REQ-008 The memory access SHALL take place on the edge that enters RESP; rsp_valid SHALL rise WAIT_CYC+1 cycles after the accept edge.
REQ-009 A store SHALL write only the lanes whose req_be bit is 1; the other lanes keep their old values.
REQ-010 rsp_rd SHALL be the addressed word after the access, including for stores (read-after-write value).
REQ-011 A load SHALL ignore req_be and never modify memory.
REQ-012 In RESP, rsp_valid, rsp_rd and rsp_err SHALL stay stable until rsp_ready is 1; on that handshake edge the FSM SHALL return to IDLE.
REQ-013 rsp_ready held at 0 SHALL stall in RESP indefinitely, with no further accepts.
REQ-014 The earliest next accept SHALL be the cycle after the response handshake; there is no overlap of transactions.
REQ-015 A store with req_be = 4'b0000 SHALL write nothing and still complete normally.

Reset
REQ-016 While reset_n is 0 (asynchronous assertion), the FSM SHALL be in IDLE and the counter SHALL be 0.
REQ-017 During reset, req_ready SHALL be 0, rsp_valid 0, rsp_rd 32'h0 and rsp_err 0; req_ready SHALL become 1 on the first clock edge after reset_n rises.
REQ-018 A reset while in WAIT SHALL discard the pending store; memory SHALL remain unmodified.
REQ-019 Memory contents SHALL not be cleared by reset.

Configuration
REQ-020 With macro DMEM_BE_CHECK_EN defined, a store SHALL be legal only if req_be and req_addr[1:0] are one of these pairs: 0001/00, 0010/01, 0100/10, 1000/11, 0011/00, 1100/10, 1111/00.
REQ-021 With DMEM_BE_CHECK_EN defined, an illegal store SHALL write nothing and SHALL return rsp_err = 1; loads SHALL never set rsp_err.
REQ-022 Without DMEM_BE_CHECK_EN, rsp_err SHALL be tied to 0 and every store SHALL write per req_be as given.

Structure
REQ-023 Package dmem_pkg SHALL hold the state enum typedef, the legal BE/offset constants, and the function be_legal(be, off).
REQ-024 The storage SHALL be a sub-module dmem_be_array: a word memory with four byte-lane write enables, synchronous write, and read data registered on the same edge.

Verification
REQ-025 The bench SHALL cover these directed scenarios (WAIT_CYC = 2):
- Store word at 0x010, be=1111, wd=0xDEADBEEF -> rsp_valid 3 cycles after accept, rsp_rd=0xDEADBEEF, rsp_err=0.
- Then store at 0x011, be=0010, wd=0x0000AA00 -> rsp_rd=0xDEADAAEF; then load 0x010 -> rsp_rd=0xDEADAAEF.
- Store at 0x012, be=1100, wd=0x12340000 -> rsp_rd=0x1234AAEF.
- rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_rd stable, req_ready=0; release -> IDLE on the next edge.
- reset_n pulsed low during WAIT of a store (be=1111, wd=0x0) to 0x010 -> rsp_valid=0 and req_ready=0 immediately; subsequent load of 0x010 returns 0x1234AAEF.
- With DMEM_BE_CHECK_EN, store be=0110 at 0x011 -> rsp_err=1 and memory unchanged; without the macro -> rsp_err=0 and lanes 1 and 2 written.
